// File: rtl/decode_fetch_sequencer.sv
// Fetch-to-decode byte sequencer: buffers fetch beats, presents a 15-byte
// window to the combinational decoder, and registers one instruction record
// per decode behind a valid/ready handshake.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_FILL   | fewer than 15 bytes buffered, decoder window not usable
// ST_DECODE | at least 15 bytes buffered, decode fires when slot free
module decode_fetch_sequencer #(
  parameter int unsigned FETCH_BYTES = 8,
  parameter int unsigned BUF_BYTES   = 32,
  parameter logic [63:0] RESET_PC    = 64'h0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fetch_valid,
  output logic                     fetch_ready,
  input  logic [FETCH_BYTES*8-1:0] fetch_data,
  input  logic                     redirect_valid,
  input  logic [63:0]              redirect_pc,
  output logic [119:0]             dc_bytes,
  input  logic [3:0]               dc_len,
  output logic                     ins_valid,
  input  logic                     ins_ready,
  output logic [119:0]             ins_bytes,
  output logic [3:0]               ins_len,
  output logic [63:0]              ins_pc,
  output logic                     dc_err,
  output logic [31:0]              ins_count
);

  localparam int unsigned CW = $clog2(BUF_BYTES + 1);
  localparam int unsigned BW = BUF_BYTES * 8;
  localparam int unsigned FW = FETCH_BYTES * 8;
  localparam logic [CW-1:0] WIN_C   = CW'(15);
  localparam logic [CW-1:0] FETCH_C = CW'(FETCH_BYTES);
  localparam logic [CW-1:0] ROOM_C  = CW'(BUF_BYTES - FETCH_BYTES);

  typedef enum logic {ST_FILL, ST_DECODE} state_e;

  // Byte 0 of the buffer sits in the MSB byte; bytes past cnt are kept zero
  // so the window needs no masking and appends can simply be OR-ed in.
  logic [BW-1:0]  buf_q, buf_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [63:0]    pc_q, pc_d;
  state_e         state_q, state_d;
  logic           ins_valid_q, ins_valid_d;
  logic [119:0]   ins_bytes_q, ins_bytes_d;
  logic [3:0]     ins_len_q, ins_len_d;
  logic [63:0]    ins_pc_q, ins_pc_d;
  logic           err_q, err_d;
  logic [31:0]    count_q, count_d;

  logic           accept;
  logic           fire;
  logic           bad_len;
  logic [3:0]     len_eff;
  logic [CW-1:0]  len_ext;
  logic [CW-1:0]  base;

  assign fetch_ready = (cnt_q <= ROOM_C) && !redirect_valid;
  assign accept      = fetch_valid && fetch_ready;
  assign dc_bytes    = buf_q[BW-1 -: 120];
  assign fire        = (state_q == ST_DECODE) && (!ins_valid_q || ins_ready) && !redirect_valid;
  assign bad_len     = (dc_len == 4'd0);
  assign len_eff     = !fire ? 4'd0 : (bad_len ? 4'd1 : dc_len);
  assign len_ext     = CW'(len_eff);
  assign base        = cnt_q - len_ext;

  assign ins_valid = ins_valid_q;
  assign ins_bytes = ins_bytes_q;
  assign ins_len   = ins_len_q;
  assign ins_pc    = ins_pc_q;
  assign dc_err    = err_q;
  assign ins_count = count_q;

  // Next-state: consume, append behind the surviving bytes, update record.
  always_comb begin
    buf_d       = buf_q << {len_eff, 3'b000};
    cnt_d       = base + (accept ? FETCH_C : '0);
    pc_d        = pc_q + 64'(len_eff);
    ins_valid_d = ins_valid_q;
    ins_bytes_d = ins_bytes_q;
    ins_len_d   = ins_len_q;
    ins_pc_d    = ins_pc_q;
    err_d       = 1'b0;
    count_d     = count_q;

    if (accept) begin
      buf_d = buf_d | ({fetch_data, {(BW-FW){1'b0}}} >> {base, 3'b000});
    end

    if (fire) begin
      err_d = bad_len;
      if (!bad_len) begin
        ins_valid_d = 1'b1;
        ins_bytes_d = dc_bytes;
        ins_len_d   = dc_len;
        ins_pc_d    = pc_q;
        count_d     = count_q + 32'd1;
      end else if (ins_ready) begin
        ins_valid_d = 1'b0;
      end
    end else if (ins_ready) begin
      ins_valid_d = 1'b0;
    end

    state_d = (cnt_d >= WIN_C) ? ST_DECODE : ST_FILL;

    if (redirect_valid) begin
      buf_d       = '0;
      cnt_d       = '0;
      pc_d        = redirect_pc;
      ins_valid_d = 1'b0;
      err_d       = 1'b0;
      state_d     = ST_FILL;
    end
  end

  // State and record registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q       <= '0;
      cnt_q       <= '0;
      pc_q        <= RESET_PC;
      state_q     <= ST_FILL;
      ins_valid_q <= 1'b0;
      ins_bytes_q <= '0;
      ins_len_q   <= '0;
      ins_pc_q    <= '0;
      err_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      pc_q        <= pc_d;
      state_q     <= state_d;
      ins_valid_q <= ins_valid_d;
      ins_bytes_q <= ins_bytes_d;
      ins_len_q   <= ins_len_d;
      ins_pc_q    <= ins_pc_d;
      err_q       <= err_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_decode_fetch_sequencer.sv
// Bench for decode_fetch_sequencer: a byte-queue reference model plus a few
// hand-computed expectations.
module tb_decode_fetch_sequencer;

  localparam int FB  = 8;
  localparam int BUF = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            fetch_valid;
  logic            fetch_ready;
  logic [FB*8-1:0] fetch_data;
  logic            redirect_valid;
  logic [63:0]     redirect_pc;
  logic [119:0]    dc_bytes;
  logic [3:0]      dc_len;
  logic            ins_valid;
  logic            ins_ready;
  logic [119:0]    ins_bytes;
  logic [3:0]      ins_len;
  logic [63:0]     ins_pc;
  logic            dc_err;
  logic [31:0]     ins_count;

  decode_fetch_sequencer #(.FETCH_BYTES(FB), .BUF_BYTES(BUF), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_data(fetch_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dc_bytes(dc_bytes), .dc_len(dc_len),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_bytes(ins_bytes),
    .ins_len(ins_len), .ins_pc(ins_pc), .dc_err(dc_err), .ins_count(ins_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the buffer is just a queue of bytes.
  logic [7:0]   mq[$];
  logic [63:0]  m_pc;
  logic         m_valid;
  logic [119:0] m_bytes;
  logic [3:0]   m_len;
  logic [63:0]  m_ipc;
  logic         m_err;
  logic [31:0]  m_count;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    mq.delete();
    m_pc = 64'h0; m_valid = 1'b0; m_bytes = '0; m_len = '0;
    m_ipc = '0; m_err = 1'b0; m_count = '0;
  endtask

  function automatic logic [119:0] m_window();
    logic [119:0] w;
    w = '0;
    for (int i = 0; i < 15; i++)
      if (i < mq.size()) w[119-8*i -: 8] = mq[i];
    return w;
  endfunction

  task automatic m_update();
    logic [119:0] w;
    int  L;
    bit  can_fetch;
    bit  fire;
    w = m_window();
    can_fetch = (mq.size() <= BUF - FB);
    fire = (mq.size() >= 15) && (!m_valid || ins_ready);
    m_err = 1'b0;
    if (redirect_valid) begin
      mq.delete();
      m_valid = 1'b0;
      m_pc = redirect_pc;
    end else begin
      if (fire) begin
        L = (dc_len == 0) ? 1 : int'(dc_len);
        if (dc_len == 0) begin
          m_err = 1'b1;
          if (ins_ready) m_valid = 1'b0;
        end else begin
          m_valid = 1'b1; m_bytes = w; m_len = dc_len; m_ipc = m_pc;
          m_count = m_count + 32'd1;
        end
        for (int k = 0; k < L; k++) void'(mq.pop_front());
        m_pc = m_pc + 64'(L);
      end else if (ins_ready) begin
        m_valid = 1'b0;
      end
      if (fetch_valid && can_fetch)
        for (int j = 0; j < FB; j++) mq.push_back(fetch_data[(FB-1-j)*8 +: 8]);
    end
  endtask

  task automatic check_all();
    chk("fetch_ready", 128'(fetch_ready), 128'((mq.size() <= BUF - FB) && !redirect_valid));
    chk("dc_bytes",    128'(dc_bytes),    128'(m_window()));
    chk("ins_valid",   128'(ins_valid),   128'(m_valid));
    if (m_valid) begin
      chk("ins_bytes", 128'(ins_bytes), 128'(m_bytes));
      chk("ins_len",   128'(ins_len),   128'(m_len));
      chk("ins_pc",    128'(ins_pc),    128'(m_ipc));
    end
    chk("dc_err",      128'(dc_err),      128'(m_err));
    chk("ins_count",   128'(ins_count),   128'(m_count));
  endtask

  // Drive one cycle's inputs (at the falling edge), check, then advance.
  task automatic step(input logic fv, input logic [FB*8-1:0] fd, input logic rv,
                      input logic [63:0] rpc, input logic [3:0] len, input logic rdy);
    fetch_valid = fv; fetch_data = fd; redirect_valid = rv;
    redirect_pc = rpc; dc_len = len; ins_ready = rdy;
    #1;
    check_all();
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  logic [119:0] exp_win;
  logic [FB*8-1:0] nops;

  initial begin
    rst_n = 1'b0; fetch_valid = 0; fetch_data = '0; redirect_valid = 0;
    redirect_pc = '0; dc_len = 4'd1; ins_ready = 0;
    m_reset();
    nops = {FB{8'h90}};
    #12;
    chk("rst_ins_valid", 128'(ins_valid), 128'(0));
    chk("rst_ins_count", 128'(ins_count), 128'(0));
    chk("rst_dc_bytes",  128'(dc_bytes),  128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_fetch_ready", 128'(fetch_ready), 128'(1));

    // Two NOP beats, stub length 1, downstream always ready.
    step(1'b1, nops, 1'b0, '0, 4'd1, 1'b1);
    step(1'b1, nops, 1'b0, '0, 4'd1, 1'b1);
    chk("t1_no_rec_yet", 128'(ins_valid), 128'(0));
    step(1'b0, nops, 1'b0, '0, 4'd1, 1'b1);
    chk("t1_first_valid", 128'(ins_valid), 128'(1));
    chk("t1_first_pc",    128'(ins_pc),    128'(0));
    chk("t1_first_len",   128'(ins_len),   128'(1));
    step(1'b0, nops, 1'b0, '0, 4'd1, 1'b1);
    chk("t1_second_pc",   128'(ins_pc),    128'(1));
    step(1'b0, nops, 1'b0, '0, 4'd1, 1'b1);
    exp_win = {{14{8'h90}}, 8'h00};
    chk("t1_fill_valid",  128'(ins_valid), 128'(0));
    chk("t1_fill_count",  128'(ins_count), 128'(2));
    chk("t1_fill_window", 128'(dc_bytes),  128'(exp_win));

    // Redirect with a same-cycle beat: beat dropped, buffer empty.
    step(1'b1, 64'h0102030405060708, 1'b1, 64'h1000, 4'd4, 1'b1);
    chk("t5_valid_cleared", 128'(ins_valid), 128'(0));
    chk("t5_window_empty",  128'(dc_bytes),  128'(0));
    step(1'b1, 64'h1112131415161718, 1'b0, '0, 4'd4, 1'b0);
    step(1'b1, 64'h2122232425262728, 1'b0, '0, 4'd4, 1'b0);
    step(1'b0, nops, 1'b0, '0, 4'd4, 1'b0);
    chk("t5_first_pc",  128'(ins_pc),  128'(64'h1000));
    chk("t5_first_len", 128'(ins_len), 128'(4));
    // Refill to 20, then an invalid length skips one byte with no record.
    step(1'b1, 64'h3132333435363738, 1'b0, '0, 4'd4, 1'b0);
    step(1'b0, nops, 1'b0, '0, 4'd0, 1'b1);
    chk("t4_dc_err",   128'(dc_err),    128'(1));
    chk("t4_no_rec",   128'(ins_valid), 128'(0));
    step(1'b0, nops, 1'b0, '0, 4'd2, 1'b0);
    chk("t4_err_pulse", 128'(dc_err), 128'(0));
    chk("t4_skip_pc",   128'(ins_pc), 128'(64'h1005));
    step(1'b0, nops, 1'b0, '0, 4'd7, 1'b0);
    chk("t2_held_pc",   128'(ins_pc), 128'(64'h1005));

    // Asynchronous reset while a record is held.
    #3 rst_n = 1'b0;
    #1;
    chk("t6_valid", 128'(ins_valid), 128'(0));
    chk("t6_pc",    128'(ins_pc),    128'(0));
    chk("t6_len",   128'(ins_len),   128'(0));
    chk("t6_bytes", 128'(ins_bytes), 128'(0));
    chk("t6_count", 128'(ins_count), 128'(0));
    chk("t6_win",   128'(dc_bytes),  128'(0));
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("t6_fetch_ready", 128'(fetch_ready), 128'(1));

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] len;
      int r;
      r = $urandom_range(0, 31);
      len = (r < 2) ? 4'd0 : 4'((r % 15) + 1);
      step(($urandom_range(0, 9) < 7),
           {$urandom(), $urandom()},
           ($urandom_range(0, 99) < 3),
           {$urandom(), $urandom()},
           len,
           ($urandom_range(0, 9) < 6));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
